// File: rtl/rv_pkg.sv
// Shared RISC-V decode constants for the front-end pipeline stages.
package rv_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam int unsigned REG_FW  = 5;
   localparam int unsigned RD_LSB  = 7;
   localparam int unsigned RS1_LSB = 15;
   localparam int unsigned RS2_LSB = 20;

   function automatic logic [4:0] rs1_of(input logic [31:0] ir);
      return ir[RS1_LSB +: REG_FW];
   endfunction

   function automatic logic [4:0] rs2_of(input logic [31:0] ir);
      return ir[RS2_LSB +: REG_FW];
   endfunction

   // x0 and indices beyond the implemented file (RV32E) are never stored.
   function automatic logic reg_valid(input logic [4:0] idx, input int unsigned nregs);
      return (idx != 5'd0) && (32'(idx) < nregs);
   endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RISC-V immediate generator: 32-bit instruction in, sign-extended
// XLEN immediate out. Unknown opcodes produce zero.
module rv_imm_gen
   import rv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     ir,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (ir[6:0])
         OP_LUI, OP_AUIPC: imm32 = {ir[31:12], 12'b0};
         OP_JAL:           imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         OP_JALR, OP_LOAD, OP_IMM: imm32 = {{20{ir[31]}}, ir[31:20]};
         OP_BRANCH:        imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OP_STORE:         imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         default:          imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/read_stage_mp.sv
// Register-read / immediate stage: multi-port register file with write bypass and a
// single output slot behind a valid/ready handshake.
module read_stage_mp
   import rv_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEFAULT,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned WB_PORTS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              ir_in,
   input  logic [XLEN-1:0]          pc_in,
   input  logic                     v_in,
   output logic                     r_out,
   input  logic [WB_PORTS-1:0]      wb_we,
   input  logic [WB_PORTS*5-1:0]    wb_addr,
   input  logic [WB_PORTS*XLEN-1:0] wb_data,
   input  logic                     stall,
   input  logic                     flush,
   output logic [31:0]              ir_out,
   output logic [XLEN-1:0]          pc_out,
   output logic [XLEN-1:0]          a_out,
   output logic [XLEN-1:0]          b_out,
   output logic [XLEN-1:0]          i_out,
   output logic                     v_out,
   input  logic                     r_in
);

   localparam int unsigned AW = $clog2(NREGS);

   logic [XLEN-1:0] rf_q [NREGS];
   logic            full_q, full_d;
   logic [31:0]     ir_q;
   logic [XLEN-1:0] pc_q, a_q, b_q, i_q;

   logic            accept, drain;
   logic [XLEN-1:0] imm;
   logic [4:0]      rs1_in, rs2_in, rs1_held, rs2_held;
   logic [XLEN-1:0] rs1_val, rs2_val, rs1_wb, rs2_wb;
   logic            rs1_hit, rs2_hit;
   logic [WB_PORTS-1:0] wb_wr;
   logic [AW-1:0]   wb_idx [WB_PORTS];

   // Same-cycle write-port lookup; later ports override earlier ones.
   function automatic logic wb_match(input logic [4:0] idx,
                                     input logic [WB_PORTS-1:0] we,
                                     input logic [WB_PORTS*5-1:0] addr);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (we[p] && addr[p*5 +: 5] == idx) hit = 1'b1;
      end
      return hit && reg_valid(idx, NREGS);
   endfunction

   function automatic logic [XLEN-1:0] wb_value(input logic [4:0] idx,
                                                input logic [WB_PORTS-1:0] we,
                                                input logic [WB_PORTS*5-1:0] addr,
                                                input logic [WB_PORTS*XLEN-1:0] data);
      logic [XLEN-1:0] val;
      val = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (we[p] && addr[p*5 +: 5] == idx) val = data[p*XLEN +: XLEN];
      end
      return val;
   endfunction

   rv_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .ir  (ir_in),
      .imm (imm)
   );

   assign v_out  = full_q & ~stall;
   assign r_out  = ~stall & (~full_q | r_in);
   assign accept = v_in & r_out & ~flush;
   assign drain  = v_out & r_in;

   always_comb begin
      full_d = full_q;
      if (flush)       full_d = 1'b0;
      else if (accept) full_d = 1'b1;
      else if (drain)  full_d = 1'b0;
   end

   always_comb begin
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_wr[p]  = wb_we[p] & reg_valid(wb_addr[p*5 +: 5], NREGS);
         wb_idx[p] = wb_addr[p*5 +: AW];
      end
   end

   always_comb begin
      rs1_in   = rs1_of(ir_in);
      rs2_in   = rs2_of(ir_in);
      rs1_held = rs1_of(ir_q);
      rs2_held = rs2_of(ir_q);

      rs1_val = '0;
      if (reg_valid(rs1_in, NREGS)) begin
         rs1_val = wb_match(rs1_in, wb_we, wb_addr) ? wb_value(rs1_in, wb_we, wb_addr, wb_data)
                                                    : rf_q[rs1_in[AW-1:0]];
      end
      rs2_val = '0;
      if (reg_valid(rs2_in, NREGS)) begin
         rs2_val = wb_match(rs2_in, wb_we, wb_addr) ? wb_value(rs2_in, wb_we, wb_addr, wb_data)
                                                    : rf_q[rs2_in[AW-1:0]];
      end

      rs1_hit = wb_match(rs1_held, wb_we, wb_addr);
      rs2_hit = wb_match(rs2_held, wb_we, wb_addr);
      rs1_wb  = wb_value(rs1_held, wb_we, wb_addr, wb_data);
      rs2_wb  = wb_value(rs2_held, wb_we, wb_addr, wb_data);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
      end else begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_wr[p]) rf_q[wb_idx[p]] <= wb_data[p*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         ir_q   <= '0;
         pc_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         i_q    <= '0;
      end else begin
         full_q <= full_d;
         if (accept) begin
            ir_q <= ir_in;
            pc_q <= pc_in;
            a_q  <= rs1_val;
            b_q  <= rs2_val;
            i_q  <= imm;
         end else if (full_q) begin
            // Keep a stalled/backpressured slot's operands coherent with writeback.
            if (rs1_hit) a_q <= rs1_wb;
            if (rs2_hit) b_q <= rs2_wb;
         end
      end
   end

   assign ir_out = ir_q;
   assign pc_out = pc_q;
   assign a_out  = a_q;
   assign b_out  = b_q;
   assign i_out  = i_q;

endmodule
